// File: rtl/rgba_avst_pkg.sv
// rgba_avst_pkg: shared state encoding, Avalon-ST packet type and RGBA field layout
package rgba_avst_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PIX  = 2'd2,
    ST_PAD  = 2'd3
  } state_t;
  localparam logic [3:0] AVST_PKT_VIDEO = 4'h0;
  localparam int R_HI = 31;
  localparam int R_LO = 24;
  localparam int G_HI = 23;
  localparam int G_LO = 16;
  localparam int B_HI = 15;
  localparam int B_LO = 8;
  function automatic logic [23:0] rgba_to_rgb(input logic [31:0] p);
    return {p[R_HI:R_LO], p[G_HI:G_LO], p[B_HI:B_LO]};
  endfunction
endpackage

// File: rtl/avst_pixel_fifo.sv
// avst_pixel_fifo: show-ahead synchronous FIFO with flush; a write into a full FIFO
// succeeds only when a read frees a slot in the same cycle
module avst_pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_rd, do_wr;
  assign count = wp - rp;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = mem[rp[AW-1:0]];
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_wr);
      rp <= rp + (AW+1)'(do_rd);
    end
  end
  always_ff @(posedge clk)
    if (do_wr && !flush) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/rgba_avst_video_tx.sv
// rgba_avst_video_tx: packs a free-running RGBA pixel stream into Avalon-ST Video
// data packets (header beat + W*H RGB beats) behind a small drop-on-overflow FIFO
module rgba_avst_video_tx
  import rgba_avst_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic [31:0] pix_data,
  input  logic        sreset,
  output logic [23:0] src_data,
  output logic        src_startofpacket,
  output logic        src_endofpacket,
  output logic [1:0]  src_empty,
  output logic        src_valid,
  input  logic        src_ready,
  output logic        overflow,
  output logic        frame_done,
  output logic        busy
);
  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW = $clog2(NPIX);
  localparam logic [CW-1:0] LAST = CW'(NPIX - 1);
  state_t state;
  logic [CW-1:0] pix_cnt;
  logic [23:0] head;
  logic full, empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic accept, last_acc, pop, drop;
  assign src_empty = 2'b00;
  assign busy = state != ST_IDLE;
  always_comb begin
    src_valid = state == ST_HDR || state == ST_PAD || (state == ST_PIX && |count);
    src_startofpacket = state == ST_HDR;
    src_endofpacket = (state == ST_PIX || state == ST_PAD) && pix_cnt == LAST;
    src_data = state == ST_HDR ? {20'h0, AVST_PKT_VIDEO} : state == ST_PIX ? head : 24'h0;
  end
  assign accept = src_valid && src_ready;
  assign last_acc = accept && src_endofpacket;
  assign pop = accept && state == ST_PIX;
  assign drop = pix_valid && !sreset && full && !pop;
  avst_pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(24)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .flush (sreset),
    .wr    (pix_valid && !sreset),
    .wdata (rgba_to_rgb(pix_data)),
    .rd    (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      pix_cnt    <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_acc;
      overflow   <= sreset ? 1'b0 : overflow | drop;
      unique case (state)
        ST_IDLE: if (!sreset && !empty) state <= ST_HDR;
        ST_HDR: begin
          if (sreset) state <= ST_IDLE;
          else if (accept) begin
            state   <= ST_PIX;
            pix_cnt <= '0;
          end
        end
        default: begin
          // a resync mid-packet finishes the open packet with zero beats instead of truncating it
          if (last_acc) state <= ST_IDLE;
          else if (sreset && state == ST_PIX) state <= ST_PAD;
          if (accept && !src_endofpacket) pix_cnt <= pix_cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rgba_avst_video_tx.sv
// tb_rgba_avst_video_tx: directed + random stimulus on two DUTs (FIFO depth 16 and 4)
// sharing inputs, each checked every cycle against a queue-based packet model
module tb_rgba_avst_video_tx;
  localparam int W = 4;
  localparam int H = 2;
  localparam int NP = W * H;
  localparam int P_IDLE = 0;
  localparam int P_HDR = 1;
  localparam int P_DATA = 2;
  localparam int P_PAD = 3;
  logic clk = 1'b0;
  logic reset, pix_valid, sreset, src_ready;
  logic [31:0] pix_data;
  logic [23:0] data_o [2];
  logic [1:0] empty_o [2];
  logic [1:0] valid_o, sop_o, eop_o, ovf_o, fd_o, busy_o;
  int checks = 0;
  int failures = 0;
  int ph [2], cnt [2], mh [2], mn [2], beats [2], fdn [2];
  int dep [2] = '{16, 4};
  bit ovf [2], fd [2];
  logic [23:0] mb [2][16];
  always #5 clk = ~clk;
  rgba_avst_video_tx #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(16)) u16 (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data), .sreset(sreset),
    .src_data(data_o[0]), .src_startofpacket(sop_o[0]), .src_endofpacket(eop_o[0]),
    .src_empty(empty_o[0]), .src_valid(valid_o[0]), .src_ready(src_ready),
    .overflow(ovf_o[0]), .frame_done(fd_o[0]), .busy(busy_o[0]));
  rgba_avst_video_tx #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data), .sreset(sreset),
    .src_data(data_o[1]), .src_startofpacket(sop_o[1]), .src_endofpacket(eop_o[1]),
    .src_empty(empty_o[1]), .src_valid(valid_o[1]), .src_ready(src_ready),
    .overflow(ovf_o[1]), .frame_done(fd_o[1]), .busy(busy_o[1]));
  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s[dut%0d] got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask
  function automatic bit m_valid(input int k);
    return ph[k] == P_HDR || ph[k] == P_PAD || (ph[k] == P_DATA && mn[k] > 0);
  endfunction
  function automatic bit m_eop(input int k);
    return (ph[k] == P_DATA || ph[k] == P_PAD) && cnt[k] == NP - 1;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = P_IDLE; cnt[k] = 0; mh[k] = 0; mn[k] = 0; ovf[k] = 0; fd[k] = 0;
    end
  endtask
  task automatic model_edge(input int k, input bit pv, input logic [31:0] pd, input bit sr, input bit rdy);
    bit v, e, acc;
    int n0;
    v = m_valid(k);
    e = m_eop(k);
    acc = v && rdy;
    n0 = mn[k];
    fd[k] = acc && e;
    if (sr) begin
      mn[k] = 0; mh[k] = 0; ovf[k] = 0;
    end else begin
      if (ph[k] == P_DATA && acc) begin mh[k] = (mh[k] + 1) % 16; mn[k]--; end
      if (pv) begin
        if (mn[k] < dep[k]) begin
          mb[k][(mh[k] + mn[k]) % 16] = {pd[31:24], pd[23:16], pd[15:8]};
          mn[k]++;
        end else ovf[k] = 1;
      end
    end
    if (ph[k] == P_IDLE) begin
      if (!sr && n0 > 0) ph[k] = P_HDR;
    end else if (ph[k] == P_HDR) begin
      if (sr) ph[k] = P_IDLE;
      else if (acc) begin ph[k] = P_DATA; cnt[k] = 0; end
    end else begin
      if (acc && e) ph[k] = P_IDLE;
      else if (sr && ph[k] == P_DATA) ph[k] = P_PAD;
      if (acc && !e) cnt[k]++;
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("valid", k, 32'(valid_o[k]), 32'(m_valid(k)));
      chk("sop", k, 32'(sop_o[k]), 32'(ph[k] == P_HDR));
      chk("busy", k, 32'(busy_o[k]), 32'(ph[k] != P_IDLE));
      chk("overflow", k, 32'(ovf_o[k]), 32'(ovf[k]));
      chk("frame_done", k, 32'(fd_o[k]), 32'(fd[k]));
      chk("empty", k, 32'(empty_o[k]), 32'd0);
      if (m_valid(k)) begin
        chk("eop", k, 32'(eop_o[k]), 32'(m_eop(k)));
        chk("data", k, 32'(data_o[k]), ph[k] == P_DATA ? 32'(mb[k][mh[k]]) : 32'd0);
      end
      if (fd_o[k]) fdn[k]++;
    end
  endtask
  task automatic tick(input bit pv, input logic [31:0] pd, input bit sr, input bit rdy, input bit rs);
    pix_valid = pv; pix_data = pd; sreset = sr; src_ready = rdy; reset = rs;
    if (rs) model_reset();
    #1;
    check_all();
    for (int k = 0; k < 2; k++) if (valid_o[k] && rdy && !rs) beats[k]++;
    @(posedge clk);
    if (!rs) for (int k = 0; k < 2; k++) model_edge(k, pv, pd, sr, rdy);
    @(negedge clk);
  endtask
  function automatic logic [31:0] pix(input int n);
    logic [7:0] b;
    b = 8'(n);
    return {b, b, b, 8'($urandom)};
  endfunction
  task automatic restart();
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0);
    beats = '{0, 0};
    fdn = '{0, 0};
  endtask
  initial begin
    model_reset();
    tick(0, 0, 0, 0, 1);
    chk("rst_valid", 0, 32'(valid_o[0]), 32'd0);
    chk("rst_data", 0, 32'(data_o[0]), 32'd0);
    // back-to-back frame with ready held high
    restart();
    for (int n = 0; n < NP; n++) tick(1, pix(n + 1), 0, 1, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, 0);
    chk("t1_beats", 0, 32'(beats[0]), 32'(NP + 1));
    chk("t1_frames", 0, 32'(fdn[0]), 32'd1);
    chk("t1_ovf", 0, 32'(ovf_o[0]), 32'd0);
    // ready toggling every cycle
    restart();
    for (int n = 0; n < NP; n++) tick(1, pix(n + 1), 0, n % 2 == 0, 0);
    for (int i = 0; i < 20; i++) tick(0, 0, 0, i % 2 == 0, 0);
    chk("t2_beats", 0, 32'(beats[0]), 32'(NP + 1));
    chk("t2_ovf", 0, 32'(ovf_o[0]), 32'd0);
    // stalled sink: depth-4 instance drops half the frame
    restart();
    for (int i = 0; i < 10; i++) tick(i < NP, pix(i + 1), 0, 0, 0);
    chk("t3_ovf4", 1, 32'(ovf_o[1]), 32'd1);
    chk("t3_ovf16", 0, 32'(ovf_o[0]), 32'd0);
    for (int i = 0; i < 12; i++) tick(0, 0, 0, 1, 0);
    chk("t3_beats4", 1, 32'(beats[1]), 32'd5);
    chk("t3_busy4", 1, 32'(busy_o[1]), 32'd1);
    // resync after 3 pixel beats accepted
    restart();
    for (int n = 0; n < 4; n++) tick(1, pix(n + 1), 0, 1, 0);
    for (int i = 0; i < 20 && !(ph[0] == P_DATA && cnt[0] == 3); i++) tick(0, 0, 0, 1, 0);
    chk("t4_cnt", 0, 32'(cnt[0]), 32'd3);
    tick(1, pix(9), 1, 0, 0);
    beats = '{0, 0};
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, 0);
    chk("t4_pad_beats", 0, 32'(beats[0]), 32'(NP - 3));
    chk("t4_frames", 0, 32'(fdn[0]), 32'd1);
    chk("t4_idle", 0, 32'(busy_o[0]), 32'd0);
    chk("t4_ovf", 0, 32'(ovf_o[0]), 32'd0);
    // write while full on a popping cycle
    restart();
    for (int n = 0; n < 4; n++) tick(1, pix(n + 1), 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    tick(1, pix(5), 0, 1, 0);
    chk("t5_ovf4", 1, 32'(ovf_o[1]), 32'd0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 1, 0);
    chk("t5_beats4", 1, 32'(beats[1]), 32'd6);
    // reset in the middle of a packet
    restart();
    for (int n = 0; n < 4; n++) tick(1, pix(n + 1), 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    chk("t6_mid", 0, 32'(ph[0]), 32'(P_DATA));
    tick(0, 0, 0, 1, 1);
    chk("t6_rst_valid", 0, 32'(valid_o[0]), 32'd0);
    chk("t6_rst_busy", 0, 32'(busy_o[0]), 32'd0);
    beats = '{0, 0};
    fdn = '{0, 0};
    for (int n = 0; n < NP; n++) tick(1, pix(n + 1), 0, 1, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, 0);
    chk("t6_beats", 0, 32'(beats[0]), 32'(NP + 1));
    chk("t6_frames", 0, 32'(fdn[0]), 32'd1);
    // random traffic
    for (int i = 0; i < 600; i++)
      tick($urandom_range(3, 0) != 0, $urandom, $urandom_range(60, 0) == 0,
           $urandom_range(4, 0) < 3, $urandom_range(150, 0) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rgba_avst_video_tx.md
# rgba_avst_video_tx

Converts the free-running 32-bit RGBA pixel stream (valid-only, no backpressure) into Avalon-ST Video data packets on a 24-bit RGB source interface with sop/eop/empty and ready/valid backpressure. It feeds the video subsystem's feed-forward sink, the transmit counterpart of the scaler source, so processed frames re-enter the video pipeline. A small pixel FIFO absorbs backpressure. Overflow is flagged, never stalled.

## Interface
- IMG_WIDTH, 320, pixels per line
- IMG_HEIGHT, 240, lines per frame
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, ≥ 2
- clk  in  1  single clock; every flop is in this domain
- reset  in  1  asynchronous, active-high
- pix_valid  in  1  pixel strobe; no backpressure to the producer
- pix_data  in  32  R[31:24] G[23:16] B[15:8] A[7:0]
- sreset  in  1  synchronous stream resync
- src_data  out  24  R[23:16] G[15:8] B[7:0]
- src_startofpacket  out  1
- src_endofpacket  out  1
- src_empty  out  2  constant 0
- src_valid  out  1
- src_ready  in  1
- overflow  out  1  sticky pixel-drop flag
- frame_done  out  1  one-cycle pulse per packet closed
- busy  out  1  state ≠ IDLE

## Operation
- FIFO write: pix_valid, alpha discarded.
  - If the FIFO is full and no read occurs in the same cycle, the pixel is dropped and overflow is set.
  - If the FIFO is full and a read occurs in the same cycle, the write succeeds.
- overflow clears only on reset or sreset.
- States: IDLE, HDR, PIX, PAD.
- IDLE: src_valid=0. Go to HDR when the FIFO is non-empty.
- HDR: drive src_valid=1, sop=1, eop=0, src_data=24'h0 (packet type 0 = video data). On accept (valid&&ready), go to PIX and set pix_cnt=0.
- PIX: src_valid = FIFO non-empty. src_data = FIFO head RGB.
  - eop=1 when pix_cnt == W*H−1.
  - On accept, pop the FIFO and increment pix_cnt.
  - On accept with eop: go to IDLE and pulse frame_done.
- PAD: src_valid=1, src_data=0, eop at pix_cnt == W*H−1. Never pops the FIFO. Accept with eop goes to IDLE and pulses frame_done.
- sreset, any state: flush the FIFO, clear overflow, and ignore pix_valid that cycle.
  - In HDR or IDLE: go to IDLE.
  - In PIX: go to PAD with pix_cnt unchanged, so the open packet is closed with zero pixels and the protocol is never violated.
  - In PAD: no state effect.
- pix_cnt width: $clog2(IMG_WIDTH*IMG_HEIGHT). It never wraps inside a packet and resets to 0 on each HDR accept.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE
  - FIFO empty
  - pix_cnt 0
- Pixel written at edge t: FIFO non-empty after t, state HDR after t+1, header valid in the cycle after t+1.
- First pixel beat is valid in the cycle after header accept if the FIFO is still non-empty.
- Sustained throughput is one beat per clock while src_ready=1.
- Avalon-ST hold rule: while src_valid && !src_ready, src_data, sop and eop are stable and src_valid stays high. The FIFO head does not change because there is no pop.
- src_ready is honoured with zero ready-latency.
- frame_done asserts in the cycle after the eop-accept edge, for one cycle.
- reset mid-packet: immediate return to IDLE. No packet closure; downstream is reset as well.

## Structure
- Package rgba_avst_pkg holds:
  - the state enum
  - AVST_PKT_VIDEO = 4'h0
  - the RGBA field slice constants
- One sub-module, avst_pixel_fifo: synchronous show-ahead FIFO, parameterised depth and width 24, with full/empty/count outputs and a flush input.
- Top-level FSM, counter and flags stay in rgba_avst_video_tx.

## Test plan
- W=4, H=2, src_ready=1, 8 back-to-back pixels 32'hRRGGBBAA with RR=n → header beat 24'h0 with sop, then 8 beats data {n,n,n} in order, eop on the 8th, frame_done once, overflow=0.
- Same stimulus with src_ready toggling 1/0 each cycle, DEPTH=16 → identical beat sequence, held stable during stalls, no overflow.
- DEPTH=4, src_ready=0 for 10 cycles while 8 pixels arrive → 4 pixels dropped, overflow=1; the packet carries only pixels 0..3 after ready rises, then waits.
- sreset after 3 pixel beats accepted (W*H=8) → 5 zero beats, eop on the 5th, frame_done, FIFO empty, overflow cleared.
- Write on the same cycle as a pop with the FIFO full → pixel retained, overflow stays 0.
- Assert reset during PIX → all outputs 0 next cycle; the next frame starts with a fresh header and pix_cnt=0.
